rob_commit: RTL
===============

Name: rob_commit

Overview:
- Reorder buffer for the out-of-order RV32I core: a circular queue of in-flight instructions.
- Allocates an entry on each decoder issue and captures results broadcast by the ALU reservation station and by the LSB.
- Retires entries strictly in program order: register writes go to the register file, stores are released to the LSB.
- On a mispredicted branch it raises the pipeline-wide flush rob_clear_up together with the corrected PC.

Parameters:
ROB_SIZE, 8, number of entries (power of two)
ROB_BIT, 3, log2(ROB_SIZE); width of entry tags

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  pause when low
issue_signal  input  1  allocate one entry this cycle
issue_type  input  2  0=reg write, 1=store, 2=branch, 3=no-op/halt
issue_rd  input  5  destination register (ignored unless type 0)
issue_inst_addr  input  32  instruction PC
issue_pred_taken  input  1  predictor decision (branch only)
issue_target  input  32  branch taken target (branch only)
issue_ready  input  1  result already known at issue (lui/auipc/jal)
issue_value  input  32  result when issue_ready=1
rob_tail  output  ROB_BIT  tag the next issue receives
rob_full  output  1  no free entry
rs_ready  input  1  ALU broadcast valid
rs_rob_entry  input  ROB_BIT  ALU broadcast tag
rs_value  input  32  ALU result; for branches bit0 = actual taken
lsb_ready  input  1  LSB broadcast valid
lsb_rob_entry  input  ROB_BIT  LSB broadcast tag
lsb_value  input  32  load data, or don't-care for a resolved store
query_entry1  input  ROB_BIT  operand lookup tag 1
query_entry2  input  ROB_BIT  operand lookup tag 2
query_ready1  output  1  tag 1 result available
query_value1  output  32  tag 1 result
query_ready2  output  1  tag 2 result available
query_value2  output  32  tag 2 result
commit_valid  output  1  register write retiring
commit_rd  output  5  retiring destination register
commit_value  output  32  retiring value
commit_rob_entry  output  ROB_BIT  retiring tag (regfile clears the dependency if its tag matches)
commit_store  output  1  pulse: head store may write memory
rob_clear_up  output  1  flush pulse
clear_pc  output  32  PC to fetch after the flush

Behaviour:
Reset and pause
- rst_in (sync): head=tail=count=0; all busy/ready bits cleared; every output register 0.
- Reset overrides all other activity, including a flush or commit in progress.
- rdy_in low: all state held; commit_valid, commit_store and rob_clear_up are driven 0.

Allocation
- rob_tail = tail.
- rob_full = (count == ROB_SIZE), combinational.
- issue_signal with !rob_full writes entry[tail] = {busy=1, ready=issue_ready, fields}; tail wraps ROB_SIZE-1 -> 0.
- Issue while full is ignored; the decoder must not do this.

Writeback
- Each broadcast (rs, lsb) targeting a busy entry sets ready=1 and stores the value. Both may land in the same cycle on different tags.
- A broadcast to a non-busy tag is ignored.

Operand query
- Combinational. query_readyX = busy && ready, OR a matching same-cycle rs/lsb broadcast (bypass; the broadcast value takes priority).
- Both query ports are independent.

Commit
- At most one entry per cycle, only when entry[head] is busy && ready.
- Commit outputs are registered: valid in the cycle after the commit edge, high for one cycle.
- Type 0: commit_valid=1 with rd/value/tag. An entry with rd=0 still commits, with commit_valid=1 and commit_rd=0.
- Type 1: commit_store=1.
- Type 3: silent retire.
- Type 2, actual==pred: silent retire.
- Type 2, actual!=pred: rob_clear_up=1 next cycle, clear_pc = actual ? target : inst_addr+4. At the same edge all entries are invalidated and head=tail=count=0.
- During the rob_clear_up cycle, issue and broadcasts are ignored.

Occupancy and latency
- count updates by +issue -commit. Simultaneous issue and commit keeps count unchanged.
- At full, a same-cycle issue is still rejected because rob_full is sampled before the commit.
- Head and tail wrap independently.
- Minimum latency: issue with issue_ready at edge N -> commit edge N+1 -> outputs visible in cycle N+1.

Test Plan:
1. Issue 3 reg-writes (rd=1,2,3); broadcast tags 2,0,1 in separate cycles with values 0x22,0x00,0x11 -> commits appear in order tag0/rd1/0x00, tag1/rd2/0x11, tag2/rd3/0x22 on consecutive cycles.
2. Issue 8 entries -> rob_full=1, rob_tail=0. A 9th issue is ignored. Commit one while issuing in the same cycle -> issue rejected, count=7. Next issue accepted at tag 0.
3. Branch at PC 0x100, pred_taken=1, target 0x200; rs_value=0 -> rob_clear_up pulse, clear_pc=0x104, count=0, younger ready entries never commit.
4. Same cycle: rs and lsb broadcast tags 1 and 2 while query_entry1=1, query_entry2=2 -> query_ready1/2=1 with the broadcast values.
5. Store entry resolved by lsb_ready -> single-cycle commit_store, commit_valid stays 0.
6. Hold rdy_in=0 for 3 cycles with a ready head -> no commit. Assert rst_in during a pending flush -> all outputs 0, rob_clear_up not raised.

Source files
------------

// File: rtl/rob_commit.sv
// Reorder buffer for the out-of-order RV32I core: in-order allocation and retirement,
// out-of-order result capture from the ALU and LSB broadcast buses.
module rob_commit #(
    parameter int ROB_SIZE = 8,
    parameter int ROB_BIT  = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,

    input  logic               issue_signal,
    input  logic [1:0]         issue_type,
    input  logic [4:0]         issue_rd,
    input  logic [31:0]        issue_inst_addr,
    input  logic               issue_pred_taken,
    input  logic [31:0]        issue_target,
    input  logic               issue_ready,
    input  logic [31:0]        issue_value,
    output logic [ROB_BIT-1:0] rob_tail,
    output logic               rob_full,

    input  logic               rs_ready,
    input  logic [ROB_BIT-1:0] rs_rob_entry,
    input  logic [31:0]        rs_value,
    input  logic               lsb_ready,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,

    input  logic [ROB_BIT-1:0] query_entry1,
    input  logic [ROB_BIT-1:0] query_entry2,
    output logic               query_ready1,
    output logic [31:0]        query_value1,
    output logic               query_ready2,
    output logic [31:0]        query_value2,

    output logic               commit_valid,
    output logic [4:0]         commit_rd,
    output logic [31:0]        commit_value,
    output logic [ROB_BIT-1:0] commit_rob_entry,
    output logic               commit_store,
    output logic               rob_clear_up,
    output logic [31:0]        clear_pc
);

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_STORE  = 2'd1,
        T_BRANCH = 2'd2,
        T_NOP    = 2'd3
    } rob_type_e;

    localparam logic [ROB_BIT:0]   FULL_COUNT = (ROB_BIT + 1)'(ROB_SIZE);
    localparam logic [ROB_BIT-1:0] TAG_ONE    = ROB_BIT'(1);

    logic        busy_q   [ROB_SIZE];
    logic        busy_d   [ROB_SIZE];
    logic        ready_q  [ROB_SIZE];
    logic        ready_d  [ROB_SIZE];
    rob_type_e   type_q   [ROB_SIZE];
    rob_type_e   type_d   [ROB_SIZE];
    logic [4:0]  rd_q     [ROB_SIZE];
    logic [4:0]  rd_d     [ROB_SIZE];
    logic [31:0] value_q  [ROB_SIZE];
    logic [31:0] value_d  [ROB_SIZE];
    logic [31:0] addr_q   [ROB_SIZE];
    logic [31:0] addr_d   [ROB_SIZE];
    logic        pred_q   [ROB_SIZE];
    logic        pred_d   [ROB_SIZE];
    logic [31:0] target_q [ROB_SIZE];
    logic [31:0] target_d [ROB_SIZE];

    logic [ROB_BIT-1:0] head_q, head_d;
    logic [ROB_BIT-1:0] tail_q, tail_d;
    logic [ROB_BIT:0]   count_q, count_d;

    logic               commit_valid_q, commit_valid_d;
    logic [4:0]         commit_rd_q, commit_rd_d;
    logic [31:0]        commit_value_q, commit_value_d;
    logic [ROB_BIT-1:0] commit_rob_entry_q, commit_rob_entry_d;
    logic               commit_store_q, commit_store_d;
    logic               rob_clear_up_q, rob_clear_up_d;
    logic [31:0]        clear_pc_q, clear_pc_d;

    logic issue_ok;
    logic wb_en;
    logic commit_fire;
    logic head_taken;
    logic mispredict;

    assign rob_full  = (count_q == FULL_COUNT);
    assign rob_tail  = tail_q;

    // While the flush pulse is out, new issues and stale broadcasts are dropped.
    assign wb_en       = rdy_in && !rob_clear_up_q;
    assign issue_ok    = wb_en && issue_signal && !rob_full;
    assign commit_fire = rdy_in && busy_q[head_q] && ready_q[head_q];
    assign head_taken  = value_q[head_q][0];
    assign mispredict  = commit_fire && (type_q[head_q] == T_BRANCH)
                         && (head_taken != pred_q[head_q]);

    always_comb begin
        busy_d   = busy_q;
        ready_d  = ready_q;
        type_d   = type_q;
        rd_d     = rd_q;
        value_d  = value_q;
        addr_d   = addr_q;
        pred_d   = pred_q;
        target_d = target_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        // Pulses are held during a pause and gated at the port, so none is lost.
        commit_valid_d     = commit_valid_q;
        commit_rd_d        = commit_rd_q;
        commit_value_d     = commit_value_q;
        commit_rob_entry_d = commit_rob_entry_q;
        commit_store_d     = commit_store_q;
        rob_clear_up_d     = rob_clear_up_q;
        clear_pc_d         = clear_pc_q;

        if (rdy_in) begin
            commit_valid_d = 1'b0;
            commit_store_d = 1'b0;
            rob_clear_up_d = 1'b0;

            if (wb_en && rs_ready && busy_q[rs_rob_entry]) begin
                ready_d[rs_rob_entry] = 1'b1;
                value_d[rs_rob_entry] = rs_value;
            end
            if (wb_en && lsb_ready && busy_q[lsb_rob_entry]) begin
                ready_d[lsb_rob_entry] = 1'b1;
                value_d[lsb_rob_entry] = lsb_value;
            end

            if (issue_ok) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = issue_ready;
                type_d[tail_q]   = rob_type_e'(issue_type);
                rd_d[tail_q]     = issue_rd;
                value_d[tail_q]  = issue_value;
                addr_d[tail_q]   = issue_inst_addr;
                pred_d[tail_q]   = issue_pred_taken;
                target_d[tail_q] = issue_target;
                tail_d           = tail_q + TAG_ONE;
            end

            if (commit_fire) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + TAG_ONE;
                case (type_q[head_q])
                    T_REG: begin
                        commit_valid_d     = 1'b1;
                        commit_rd_d        = rd_q[head_q];
                        commit_value_d     = value_q[head_q];
                        commit_rob_entry_d = head_q;
                    end
                    T_STORE: commit_store_d = 1'b1;
                    T_BRANCH: begin
                        if (mispredict) begin
                            rob_clear_up_d = 1'b1;
                            clear_pc_d     = head_taken ? target_q[head_q]
                                                        : addr_q[head_q] + 32'd4;
                        end
                    end
                    default: ;
                endcase
            end

            count_d = count_q + (ROB_BIT + 1)'(issue_ok) - (ROB_BIT + 1)'(commit_fire);

            if (mispredict) begin
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    busy_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]   <= 1'b0;
                ready_q[i]  <= 1'b0;
                type_q[i]   <= T_REG;
                rd_q[i]     <= '0;
                value_q[i]  <= '0;
                addr_q[i]   <= '0;
                pred_q[i]   <= 1'b0;
                target_q[i] <= '0;
            end
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            commit_valid_q     <= 1'b0;
            commit_rd_q        <= '0;
            commit_value_q     <= '0;
            commit_rob_entry_q <= '0;
            commit_store_q     <= 1'b0;
            rob_clear_up_q     <= 1'b0;
            clear_pc_q         <= '0;
        end else begin
            busy_q             <= busy_d;
            ready_q            <= ready_d;
            type_q             <= type_d;
            rd_q               <= rd_d;
            value_q            <= value_d;
            addr_q             <= addr_d;
            pred_q             <= pred_d;
            target_q           <= target_d;
            head_q             <= head_d;
            tail_q             <= tail_d;
            count_q            <= count_d;
            commit_valid_q     <= commit_valid_d;
            commit_rd_q        <= commit_rd_d;
            commit_value_q     <= commit_value_d;
            commit_rob_entry_q <= commit_rob_entry_d;
            commit_store_q     <= commit_store_d;
            rob_clear_up_q     <= rob_clear_up_d;
            clear_pc_q         <= clear_pc_d;
        end
    end

    assign commit_valid     = commit_valid_q && rdy_in;
    assign commit_rd        = commit_rd_q;
    assign commit_value     = commit_value_q;
    assign commit_rob_entry = commit_rob_entry_q;
    assign commit_store     = commit_store_q && rdy_in;
    assign rob_clear_up     = rob_clear_up_q && rdy_in;
    assign clear_pc         = clear_pc_q;

    // Operand lookup; a same-cycle broadcast wins over the stored value (rs over lsb).
    always_comb begin
        query_ready1 = busy_q[query_entry1] && ready_q[query_entry1];
        query_value1 = value_q[query_entry1];
        if (lsb_ready && lsb_rob_entry == query_entry1) begin
            query_ready1 = 1'b1;
            query_value1 = lsb_value;
        end
        if (rs_ready && rs_rob_entry == query_entry1) begin
            query_ready1 = 1'b1;
            query_value1 = rs_value;
        end

        query_ready2 = busy_q[query_entry2] && ready_q[query_entry2];
        query_value2 = value_q[query_entry2];
        if (lsb_ready && lsb_rob_entry == query_entry2) begin
            query_ready2 = 1'b1;
            query_value2 = lsb_value;
        end
        if (rs_ready && rs_rob_entry == query_entry2) begin
            query_ready2 = 1'b1;
            query_value2 = rs_value;
        end
    end

endmodule
